// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate formats and the
// per-opcode operand usage table consumed by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_t;

    typedef struct packed {
        imm_type_t imm_type;
        logic      uses_rs1;
        logic      uses_rs2;
    } op_info_t;

    // R/I/S/B formats read rs1; only R/S/B read rs2. U/J read no registers.
    function automatic op_info_t decode_opcode(input logic [6:0] opcode);
        op_info_t info;
        info.imm_type = IMM_NONE;
        info.uses_rs1 = 1'b0;
        info.uses_rs2 = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
                info.imm_type = IMM_I;
                info.uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                info.imm_type = IMM_S;
                info.uses_rs1 = 1'b1;
                info.uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                info.imm_type = IMM_B;
                info.uses_rs1 = 1'b1;
                info.uses_rs2 = 1'b1;
            end
            OP_REG, OP_REG32: begin
                info.imm_type = IMM_NONE;
                info.uses_rs1 = 1'b1;
                info.uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                info.imm_type = IMM_U;
            end
            OP_JAL: begin
                info.imm_type = IMM_J;
            end
            default: begin
                info.imm_type = IMM_NONE;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/regfile_byp.sv
// Register file with two combinational read ports, one write port and
// same-cycle write-through bypass; x0 is hardwired to zero.
module regfile_byp
    import decode_pkg::*;
#(
    parameter  int N    = 64,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata
);

    logic [N-1:0] regs_r [NREG];

    // Storage: cleared on reset (which also discards any write), x0 never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {N{1'b0}};
            end
        end else if (we && (waddr != {AW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 1: x0 first so a write to x0 can never be bypassed
    always_comb begin
        if (raddr1 == {AW{1'b0}}) begin
            rdata1 = {N{1'b0}};
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_r[raddr1];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        if (raddr2 == {AW{1'b0}}) begin
            rdata2 = {N{1'b0}};
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_r[raddr2];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: register read, immediate generation, load-use hazard
// detection and the ID/EX pipeline register.
module decode_pipe
    import decode_pkg::*;
#(
    parameter  int N    = 64,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr_D,
    input  logic          valid_D,
    input  logic          regWrite_W,
    input  logic [AW-1:0] writeAddr_W,
    input  logic [N-1:0]  writeData_W,
    input  logic          flush_E,
    output logic          stall_D,
    output logic          valid_E,
    output logic [31:0]   instr_E,
    output logic [N-1:0]  readData1_E,
    output logic [N-1:0]  readData2_E,
    output logic [N-1:0]  signImm_E,
    output logic [AW-1:0] rs1_E,
    output logic [AW-1:0] rs2_E,
    output logic [AW-1:0] rd_E
);

    logic [AW-1:0] rs1_s;
    logic [AW-1:0] rs2_s;
    logic [AW-1:0] rd_s;
    op_info_t      info_s;
    logic [31:0]   imm32_s;
    logic [N-1:0]  imm_s;
    logic [N-1:0]  rdata1_s;
    logic [N-1:0]  rdata2_s;
    logic          hazard_s;

    logic          valid_e_r;
    logic [31:0]   instr_e_r;
    logic [N-1:0]  rdata1_e_r;
    logic [N-1:0]  rdata2_e_r;
    logic [N-1:0]  imm_e_r;
    logic [AW-1:0] rs1_e_r;
    logic [AW-1:0] rs2_e_r;
    logic [AW-1:0] rd_e_r;

    assign rs1_s  = instr_D[15 +: AW];
    assign rs2_s  = instr_D[20 +: AW];
    assign rd_s   = instr_D[7 +: AW];
    assign info_s = decode_opcode(instr_D[6:0]);

    regfile_byp #(
        .N    (N),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .rdata1 (rdata1_s),
        .rdata2 (rdata2_s),
        .we     (regWrite_W),
        .waddr  (writeAddr_W),
        .wdata  (writeData_W)
    );

    // Assemble the 32-bit immediate; sign extension to N happens below
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (info_s.imm_type)
            IMM_I:    imm32_s = {{20{instr_D[31]}}, instr_D[31:20]};
            IMM_S:    imm32_s = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
            IMM_B:    imm32_s = {{19{instr_D[31]}}, instr_D[31], instr_D[7],
                                 instr_D[30:25], instr_D[11:8], 1'b0};
            IMM_U:    imm32_s = {instr_D[31:12], 12'h000};
            IMM_J:    imm32_s = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12],
                                 instr_D[20], instr_D[30:21], 1'b0};
            IMM_NONE: imm32_s = 32'h0000_0000;
            default:  imm32_s = 32'h0000_0000;
        endcase
    end

    assign imm_s = N'($signed(imm32_s));

    // Load in EX whose destination feeds an operand this instruction actually reads
    always_comb begin
        if (valid_e_r && (instr_e_r[6:0] == OP_LOAD) && (rd_e_r != {AW{1'b0}}) && valid_D) begin
            hazard_s = (info_s.uses_rs1 && (rs1_s == rd_e_r)) ||
                       (info_s.uses_rs2 && (rs2_s == rd_e_r));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush squashes decode outright, so it must never also hold fetch
    assign stall_D = hazard_s && !flush_E;

    // ID/EX register: reset, flush and hazard all insert an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset || flush_E || hazard_s) begin
            valid_e_r  <= 1'b0;
            instr_e_r  <= 32'h0000_0000;
            rdata1_e_r <= {N{1'b0}};
            rdata2_e_r <= {N{1'b0}};
            imm_e_r    <= {N{1'b0}};
            rs1_e_r    <= {AW{1'b0}};
            rs2_e_r    <= {AW{1'b0}};
            rd_e_r     <= {AW{1'b0}};
        end else begin
            valid_e_r  <= valid_D;
            instr_e_r  <= instr_D;
            rdata1_e_r <= rdata1_s;
            rdata2_e_r <= rdata2_s;
            imm_e_r    <= imm_s;
            rs1_e_r    <= rs1_s;
            rs2_e_r    <= rs2_s;
            rd_e_r     <= rd_s;
        end
    end

    assign valid_E     = valid_e_r;
    assign instr_E     = instr_e_r;
    assign readData1_E = rdata1_e_r;
    assign readData2_E = rdata2_e_r;
    assign signImm_E   = imm_e_r;
    assign rs1_E       = rs1_e_r;
    assign rs2_E       = rs2_e_r;
    assign rd_E        = rd_e_r;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning datapath width in bits (legal: 32 or 64).
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count; the address width is $clog2(NREG).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port instr_D, input, 32, meaning the instruction in decode.
REQ-006 The block SHALL have port valid_D, input, 1, meaning instr_D holds a real instruction.
REQ-007 The block SHALL have port regWrite_W, input, 1, meaning the writeback stage writes this cycle.
REQ-008 The block SHALL have port writeAddr_W, input, $clog2(NREG), meaning the writeback destination register.
REQ-009 The block SHALL have port writeData_W, input, N, meaning the writeback data.
REQ-010 The block SHALL have port flush_E, input, 1, meaning the execute stage redirected the PC (squash decode).
REQ-011 The block SHALL have port stall_D, output, 1, meaning a load-use hazard: fetch and decode hold.
REQ-012 The block SHALL have ports valid_E (1), instr_E (32), readData1_E (N), readData2_E (N) and signImm_E (N), all outputs, forming the ID/EX register contents.
REQ-013 The block SHALL have ports rs1_E, rs2_E and rd_E, outputs, $clog2(NREG) each, carrying the register addresses held in the ID/EX register.

Function
REQ-014 Register file: 2 combinational read ports and 1 write port; writes SHALL occur on the clk edge when regWrite_W=1 and writeAddr_W!=0.
REQ-015 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-016 Write-through bypass: if regWrite_W=1 and writeAddr_W equals a nonzero read address, that read port SHALL return writeData_W in the same cycle.
REQ-017 Immediate by opcode (instr_D[6:0]), sign-extended from instr[31] to N bits:
  - I (0000011, 0010011, 0011011, 1100111)
  - S (0100011)
  - B (1100011), bit0=0
  - U (0110111, 0010111), [11:0]=0
  - J (1101111), bit0=0
  - any other opcode yields 0
REQ-018 Load-use hazard SHALL be detected when all of the following hold: valid_E=1; instr_E[6:0]=0000011; rd_E!=0; valid_D=1; rd_E equals rs1 (for formats R/I/S/B) or rs2 (for formats R/S/B).
REQ-019 On hazard with flush_E=0: stall_D=1; the ID/EX register SHALL load a bubble (valid_E=0, all data 0); the upstream stage holds instr_D.
REQ-020 On flush_E=1: the ID/EX register SHALL load a bubble and stall_D SHALL be 0, regardless of any hazard; flush has priority.
REQ-021 Otherwise the ID/EX register SHALL load valid_D, instr_D, both read values, the immediate and the rs1/rs2/rd fields.
REQ-022 Latency: decode to ID/EX output SHALL be exactly 1 cycle; stall_D SHALL be combinational in the same cycle.
REQ-023 A load followed by a dependent instruction SHALL stall exactly 1 cycle; the second cycle proceeds, because the load has left EX.

Reset
REQ-024 While reset=1 at a clk edge:
  - valid_E, instr_E, all data and address outputs SHALL become 0.
  - all NREG registers SHALL become 0.
  - writes on that edge SHALL be discarded.
REQ-025 stall_D SHALL be 0 in the cycle after reset, since valid_E=0; reset mid-stall SHALL drop the pending bubble without residue.

Structure
REQ-026 Package decode_pkg SHALL hold:
  - opcode constants
  - an imm_type_t enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE)
  - a function mapping opcode to imm_type_t and rs1/rs2 usage flags
REQ-027 The register file with bypass SHALL be a sub-module named regfile_byp, parameterised by N and NREG; immediate generation and hazard logic SHALL stay in decode_pipe.

Verification
REQ-028 Reset: reset=1 for 2 cycles, then release -> valid_E=0, stall_D=0, and reading any register yields 0.
REQ-029 Bypass: regWrite_W=1, writeAddr_W=5, writeData_W=0xDEAD in the same cycle as decoding add x6,x5,x0 -> next cycle readData1_E=0xDEAD.
REQ-030 Load-use: ld x7,0(x1) followed by addi x8,x7,1 ->
  - stall_D=1 for exactly 1 cycle
  - bubble in ID/EX (valid_E=0)
  - then addi enters ID/EX with rs1_E=7
REQ-031 Flush vs hazard: assert flush_E=1 during a load-use hazard -> stall_D=0, valid_E=0 next cycle.
REQ-032 Immediates: beq with offset -4 -> signImm_E=0xFFFFFFFFFFFFFFFC; lui x1,0x12345 -> signImm_E=0x12345000; sw with offset 2047 -> 0x7FF.
REQ-033 x0: write 0x55 to register 0, then read x0 -> 0, with no bypass.
